// File: rtl/requant16_seq_ctrl.sv
// Layer sequencer for one requantize16 core: fetch acc vector, start core, wait for done,
// hand the int8 OFM vector downstream; a watchdog aborts to ERR on a hung core.
module requant16_seq_ctrl #(
  parameter int LANES   = 16,
  parameter int AW      = 20,
  parameter int PW      = 24,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       cfg_num_groups,
  input  logic [PW-1:0]       cfg_num_pix,
  input  logic [7:0]          cfg_out_zp,
  input  logic                layer_start,
  output logic                busy,
  output logic                layer_done,
  output logic                err_timeout,
  input  logic                acc_valid,
  output logic                acc_ready,
  input  logic [LANES*32-1:0] acc_vec,
  output logic                core_start,
  output logic [AW-1:0]       core_addr,
  output logic [LANES*32-1:0] core_acc_vec,
  output logic [7:0]          core_out_zp,
  input  logic                core_ready,
  input  logic                core_done,
  input  logic [LANES*8-1:0]  core_ofm_vec,
  output logic                ofm_valid,
  input  logic                ofm_ready,
  output logic [LANES*8-1:0]  ofm_data,
  output logic                ofm_last
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_HOLD, S_DONE, S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        grp_q, grp_d, ngrp_q, ngrp_d;
  logic [PW-1:0]        pix_q, pix_d, npix_q, npix_d;
  logic [7:0]           zp_q, zp_d;
  logic [LANES*32-1:0]  acc_q, acc_d;
  logic [LANES*8-1:0]   ofm_q, ofm_d;
  logic                 vld_q, vld_d, last_q, last_d, err_q, err_d;
  logic [WW-1:0]        wdog_q, wdog_d;
  logic                 grp_last, pix_last;

  assign grp_last = (grp_q == ngrp_q - AW'(1));
  assign pix_last = (pix_q == npix_q - PW'(1));

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    pix_d   = pix_q;
    ngrp_d  = ngrp_q;
    npix_d  = npix_q;
    zp_d    = zp_q;
    acc_d   = acc_q;
    ofm_d   = ofm_q;
    vld_d   = vld_q;
    last_d  = last_q;
    err_d   = err_q;
    wdog_d  = wdog_q;
    case (state_q)
      // ERR re-arms exactly like IDLE; a zero cfg count behaves as one
      S_IDLE, S_ERR: begin
        if (layer_start) begin
          ngrp_d  = (cfg_num_groups == '0) ? AW'(1) : cfg_num_groups;
          npix_d  = (cfg_num_pix == '0) ? PW'(1) : cfg_num_pix;
          zp_d    = cfg_out_zp;
          grp_d   = '0;
          pix_d   = '0;
          err_d   = 1'b0;
          wdog_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (acc_valid && core_ready) begin
          acc_d   = acc_vec;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + WW'(1);
        if (core_done) begin
          ofm_d   = core_ofm_vec;
          vld_d   = 1'b1;
          last_d  = grp_last && pix_last;
          state_d = S_HOLD;
        end else if (wdog_d == WW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      S_HOLD: begin
        if (ofm_ready) begin
          vld_d  = 1'b0;
          last_d = 1'b0;
          if (grp_last) begin
            grp_d = '0;
            pix_d = pix_q + PW'(1);
          end else begin
            grp_d = grp_q + AW'(1);
          end
          state_d = last_q ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grp_q   <= '0;
      pix_q   <= '0;
      ngrp_q  <= '0;
      npix_q  <= '0;
      zp_q    <= '0;
      acc_q   <= '0;
      ofm_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      pix_q   <= pix_d;
      ngrp_q  <= ngrp_d;
      npix_q  <= npix_d;
      zp_q    <= zp_d;
      acc_q   <= acc_d;
      ofm_q   <= ofm_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  // acc_ready depends on state and core_ready only, never on acc_valid
  assign acc_ready    = (state_q == S_FETCH) && core_ready;
  assign busy         = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                        (state_q == S_WAIT)  || (state_q == S_HOLD);
  assign layer_done   = (state_q == S_DONE);
  assign err_timeout  = err_q;
  assign core_start   = (state_q == S_ISSUE);
  assign core_addr    = grp_q;
  assign core_acc_vec = acc_q;
  assign core_out_zp  = zp_q;
  assign ofm_valid    = vld_q;
  assign ofm_data     = ofm_q;
  assign ofm_last     = last_q;

endmodule

// File: tb/tb_requant16_seq_ctrl.sv
// Directed bench for requant16_seq_ctrl with a 2-cycle core stub and a bench-side golden OFM function.
module tb_requant16_seq_ctrl;
  localparam int LANES = 16, AW = 20, PW = 24, TIMEOUT = 64;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [AW-1:0]       cfg_num_groups = '0;
  logic [PW-1:0]       cfg_num_pix = '0;
  logic [7:0]          cfg_out_zp = '0;
  logic                layer_start = 1'b0;
  logic                busy, layer_done, err_timeout;
  logic                acc_valid = 1'b0;
  logic                acc_ready;
  logic [LANES*32-1:0] acc_vec = '0;
  logic                core_start;
  logic [AW-1:0]       core_addr;
  logic [LANES*32-1:0] core_acc_vec;
  logic [7:0]          core_out_zp;
  logic                core_ready;
  logic                core_done = 1'b0;
  logic [LANES*8-1:0]  core_ofm_vec = '0;
  logic                ofm_valid;
  logic                ofm_ready = 1'b1;
  logic [LANES*8-1:0]  ofm_data;
  logic                ofm_last;

  requant16_seq_ctrl #(.LANES(LANES), .AW(AW), .PW(PW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cfg_num_groups(cfg_num_groups), .cfg_num_pix(cfg_num_pix), .cfg_out_zp(cfg_out_zp),
    .layer_start(layer_start), .busy(busy), .layer_done(layer_done), .err_timeout(err_timeout),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_vec(acc_vec),
    .core_start(core_start), .core_addr(core_addr), .core_acc_vec(core_acc_vec),
    .core_out_zp(core_out_zp), .core_ready(core_ready), .core_done(core_done),
    .core_ofm_vec(core_ofm_vec), .ofm_valid(ofm_valid), .ofm_ready(ofm_ready),
    .ofm_data(ofm_data), .ofm_last(ofm_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [LANES*32-1:0] mkvec(input int k);
    logic [LANES*32-1:0] v;
    for (int i = 0; i < LANES; i++)
      v[i*32 +: 32] = {8'(k), 8'(i), 8'hC3, 8'(k * 37 + i * 11 + 5)};
    return v;
  endfunction

  // Golden requantize result: low byte of each lane XOR a group-dependent key
  function automatic logic [LANES*8-1:0] gold(input logic [LANES*32-1:0] a, input logic [AW-1:0] g);
    logic [LANES*8-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[i*8 +: 8] = a[i*32 +: 8] ^ {g[3:0], 4'h5};
    return r;
  endfunction

  // Core stub: done two cycles after the start cycle, unless hung
  int stub_cnt  = 0;
  bit stub_hang = 1'b0;
  assign core_ready = (stub_cnt == 0);
  always @(negedge clk) begin
    if (core_done) core_done = 1'b0;
    if (stub_cnt != 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) begin
        core_done    = 1'b1;
        core_ofm_vec = gold(core_acc_vec, core_addr);
      end
    end
    if (core_start && !stub_hang) stub_cnt = 2;
  end

  // Event recorder sampled on the falling edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0]       st_addr [128];
  int                  st_cyc  [128];
  logic [LANES*32-1:0] st_acc  [128];
  logic [LANES*8-1:0]  hs_dat  [128];
  bit                  hs_last [128];
  int                  hs_cyc  [128];
  int n_st = 0, n_hs = 0, n_acc = 0, n_done = 0, done_cyc = 0, err_cyc = 0;
  int zp_bad = 0, last_bad = 0;
  logic [7:0] zp_exp = '0;
  bit err_prev = 1'b0;

  always @(negedge clk) begin
    if (core_start && n_st < 128) begin
      st_addr[n_st] = core_addr; st_cyc[n_st] = cyc; st_acc[n_st] = core_acc_vec; n_st++;
    end
    if (ofm_valid && ofm_ready && n_hs < 128) begin
      hs_dat[n_hs] = ofm_data; hs_last[n_hs] = ofm_last; hs_cyc[n_hs] = cyc; n_hs++;
    end
    if (acc_valid && acc_ready) n_acc++;
    if (layer_done) begin done_cyc = cyc; n_done++; end
    if (err_timeout && !err_prev) err_cyc = cyc;
    err_prev = err_timeout;
    if (busy && core_out_zp !== zp_exp) zp_bad++;
    if (ofm_last && !ofm_valid) last_bad++;
  end

  // Accumulator producer: presents mkvec(handshake index), optionally with random valid gaps
  bit prod_en = 1'b0, prod_rand = 1'b0;
  always begin
    @(posedge clk); #1;
    if (prod_en) begin
      acc_vec   = mkvec(n_acc);
      acc_valid = prod_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_layer(input logic [AW-1:0] g, input logic [PW-1:0] p, input logic [7:0] z);
    cfg_num_groups = g; cfg_num_pix = p; cfg_out_zp = z; zp_exp = z;
    layer_start = 1'b1;
    @(posedge clk); #1;
    layer_start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (n_done > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, layer_done, err_timeout, acc_ready, core_start, ofm_valid, ofm_last} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000",
        {busy, layer_done, err_timeout, acc_ready, core_start, ofm_valid, ofm_last});
    end
    n_checks++;
    if (core_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", core_addr); end
    n_checks++;
    if (core_out_zp !== 8'h00) begin n_fail++; $display("FAIL reset_zp: got %0d expected 0", core_out_zp); end
    n_checks++;
    if (core_acc_vec !== '0) begin n_fail++; $display("FAIL reset_acc: got %h expected 0", core_acc_vec); end
    n_checks++;
    if (ofm_data !== '0) begin n_fail++; $display("FAIL reset_ofm: got %h expected 0", ofm_data); end
  endtask

  task automatic test_basic();
    int bs, bh, ba, bd; bit ok;
    bs = n_st; bh = n_hs; ba = n_acc; bd = n_done;
    ofm_ready = 1'b1; prod_en = 1'b1;
    start_layer(3, 2, 8'hFD);
    wait_done(bd, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_done: got no layer_done expected one within 200 cycles"); end
    n_checks++;
    if (n_st - bs != 6) begin n_fail++; $display("FAIL basic_starts: got %0d expected 6", n_st - bs); end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (st_addr[bs+k] !== AW'(k % 3)) begin
        n_fail++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", k, st_addr[bs+k], k % 3);
      end
      n_checks++;
      if (st_acc[bs+k] !== mkvec(ba + k)) begin
        n_fail++; $display("FAIL basic_acc[%0d]: got %h expected %h", k, st_acc[bs+k], mkvec(ba + k));
      end
      n_checks++;
      if (hs_dat[bh+k] !== gold(mkvec(ba + k), AW'(k % 3))) begin
        n_fail++; $display("FAIL basic_ofm[%0d]: got %h expected %h", k, hs_dat[bh+k], gold(mkvec(ba + k), AW'(k % 3)));
      end
      n_checks++;
      if (hs_last[bh+k] !== (k == 5)) begin
        n_fail++; $display("FAIL basic_last[%0d]: got %0d expected %0d", k, hs_last[bh+k], k == 5);
      end
      if (k > 0) begin
        n_checks++;
        if (st_cyc[bs+k] - st_cyc[bs+k-1] != 5) begin
          n_fail++; $display("FAIL basic_spacing[%0d]: got %0d expected 5", k, st_cyc[bs+k] - st_cyc[bs+k-1]);
        end
      end
    end
    n_checks++;
    if (done_cyc - hs_cyc[bh+5] != 1) begin
      n_fail++; $display("FAIL basic_done_lat: got %0d expected 1", done_cyc - hs_cyc[bh+5]);
    end
  endtask

  task automatic test_stall();
    int bs, bh, ba, bd, stn; bit ok, seen;
    logic [LANES*8-1:0] held;
    bs = n_st; bh = n_hs; ba = n_acc; bd = n_done;
    ofm_ready = 1'b1;
    start_layer(3, 1, 8'h02);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (n_hs > bh) begin ofm_ready = 1'b0; seen = 1'b1; end
    end
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (ofm_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL stall_valid: got no ofm_valid expected vector 2"); end
    held = ofm_data; stn = n_st;
    n_checks++;
    if (held !== gold(mkvec(ba + 1), AW'(1))) begin
      n_fail++; $display("FAIL stall_data: got %h expected %h", held, gold(mkvec(ba + 1), AW'(1)));
    end
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if ({ofm_valid, acc_ready} !== 2'b10 || ofm_data !== held || n_st != stn) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got valid=%0d acc_ready=%0d starts=%0d expected 1 0 %0d",
          i, ofm_valid, acc_ready, n_st, stn);
      end
      @(posedge clk); #1;
    end
    ofm_ready = 1'b1;
    wait_done(bd, 100, ok);
    n_checks++;
    if (!ok || n_hs - bh != 3) begin
      n_fail++; $display("FAIL stall_done: got done=%0d vectors=%0d expected 1 3", ok, n_hs - bh);
    end
    n_checks++;
    if (st_cyc[bs+2] <= hs_cyc[bh+1]) begin
      n_fail++; $display("FAIL stall_order: got start at %0d expected after handshake %0d", st_cyc[bs+2], hs_cyc[bh+1]);
    end
    n_checks++;
    if (hs_last[bh+2] !== 1'b1 || hs_last[bh+1] !== 1'b0) begin
      n_fail++; $display("FAIL stall_last: got %0d%0d expected 01", hs_last[bh+1], hs_last[bh+2]);
    end
  endtask

  task automatic test_timeout();
    int bs, bh, bd; bit ok, seen;
    bs = n_st; stub_hang = 1'b1;
    start_layer(1, 1, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (err_timeout) seen = 1'b1;
    end
    @(posedge clk); #1;
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL timeout_err: got no err_timeout expected one"); end
    n_checks++;
    if (err_cyc - st_cyc[bs] != 64) begin
      n_fail++; $display("FAIL timeout_lat: got %0d expected 64", err_cyc - st_cyc[bs]);
    end
    n_checks++;
    if ({busy, acc_ready, ofm_valid, err_timeout} !== 4'b0001) begin
      n_fail++; $display("FAIL timeout_state: got %b expected 0001", {busy, acc_ready, ofm_valid, err_timeout});
    end
    stub_hang = 1'b0; bh = n_hs; bd = n_done;
    start_layer(1, 1, 8'h00);
    n_checks++;
    if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %0d expected 0", err_timeout); end
    wait_done(bd, 100, ok);
    n_checks++;
    if (!ok || n_hs - bh != 1 || hs_last[bh] !== 1'b1) begin
      n_fail++; $display("FAIL timeout_rerun: got done=%0d vectors=%0d expected 1 1", ok, n_hs - bh);
    end
  endtask

  task automatic test_reset_mid();
    int bs, bh, bd, b2; bit ok;
    bs = n_st; bd = n_done;
    start_layer(3, 2, 8'h11);
    for (int i = 0; i < 100 && n_st < bs + 4; i++) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, acc_ready, core_start, ofm_valid, ofm_last, layer_done} !== 6'b0 ||
        core_acc_vec !== '0 || core_addr !== '0 || core_out_zp !== 8'h00) begin
      n_fail++; $display("FAIL rst_async: got ctrl=%b zp=%0d acc_nonzero=%0d expected all 0",
        {busy, acc_ready, core_start, ofm_valid, ofm_last, layer_done}, core_out_zp, core_acc_vec != '0);
    end
    @(posedge clk); #1;
    rst = 1'b0; bh = n_hs;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (ofm_valid !== 1'b0 || busy !== 1'b0 || n_hs != bh) begin
      n_fail++; $display("FAIL rst_late_done: got valid=%0d busy=%0d hs=%0d expected 0 0 %0d", ofm_valid, busy, n_hs, bh);
    end
    b2 = n_st; bd = n_done;
    start_layer(3, 2, 8'h11);
    wait_done(bd, 200, ok);
    n_checks++;
    if (!ok || st_addr[b2] !== '0 || n_st - b2 != 6) begin
      n_fail++; $display("FAIL rst_restart: got done=%0d addr0=%0d starts=%0d expected 1 0 6", ok, st_addr[b2], n_st - b2);
    end
  endtask

  task automatic test_zp_random();
    int bs, bh, ba, bd, zb; bit ok;
    bs = n_st; bh = n_hs; ba = n_acc; bd = n_done; zb = zp_bad;
    prod_rand = 1'b1;
    start_layer(2, 3, 8'd37);
    wait_done(bd, 600, ok);
    prod_rand = 1'b0;
    n_checks++;
    if (!ok || n_st - bs != 6) begin n_fail++; $display("FAIL zp_done: got done=%0d starts=%0d expected 1 6", ok, n_st - bs); end
    n_checks++;
    if (zp_bad != zb || core_out_zp !== 8'd37) begin
      n_fail++; $display("FAIL zp_hold: got %0d bad cycles, zp=%0d expected 0 and 37", zp_bad - zb, core_out_zp);
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (st_acc[bs+k] !== mkvec(ba + k)) begin
        n_fail++; $display("FAIL zp_acc[%0d]: got %h expected %h", k, st_acc[bs+k], mkvec(ba + k));
      end
      n_checks++;
      if (hs_dat[bh+k] !== gold(mkvec(ba + k), AW'(k % 2))) begin
        n_fail++; $display("FAIL zp_ofm[%0d]: got %h expected %h", k, hs_dat[bh+k], gold(mkvec(ba + k), AW'(k % 2)));
      end
    end
    n_checks++;
    if (last_bad != 0) begin n_fail++; $display("FAIL last_qualify: got %0d stray cycles expected 0", last_bad); end
  endtask

  task automatic test_busy_start();
    int bs, bh, bd, zb; bit ok;
    bs = n_st; bh = n_hs; bd = n_done; zb = zp_bad;
    start_layer(2, 1, 8'd5);
    repeat (3) @(posedge clk);
    #1;
    cfg_num_groups = 7; cfg_num_pix = 9; cfg_out_zp = 8'd99;
    layer_start = 1'b1;
    @(posedge clk); #1;
    layer_start = 1'b0;
    wait_done(bd, 100, ok);
    n_checks++;
    if (!ok || n_st - bs != 2) begin n_fail++; $display("FAIL busy_ignore: got done=%0d starts=%0d expected 1 2", ok, n_st - bs); end
    n_checks++;
    if (st_addr[bs+1] !== AW'(1) || hs_last[bh] !== 1'b0 || hs_last[bh+1] !== 1'b1) begin
      n_fail++; $display("FAIL busy_seq: got addr1=%0d last=%0d%0d expected 1 01", st_addr[bs+1], hs_last[bh], hs_last[bh+1]);
    end
    n_checks++;
    if (zp_bad != zb || core_out_zp !== 8'd5) begin
      n_fail++; $display("FAIL busy_zp: got zp=%0d bad=%0d expected 5 0", core_out_zp, zp_bad - zb);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_zp_random();
    test_busy_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no end of test expected completion");
    $fatal(1);
  end

endmodule

// File: doc/requant16_seq_ctrl.md
Name: requant16_seq_ctrl

Overview:
Sequencer that drives one requantize16_top instance across a full layer. It accepts a stream of 16-lane int32 accumulator vectors and walks the channel-group address (M/E DFRAM entry) for each vector. It issues a single-cycle start to the core, waits for done, and delivers the int8 OFM vector downstream with valid/ready back-pressure. It sits between the conv accumulator stage and the OFM writer, and a watchdog flags a hung core.

Parameters:
LANES, 16, lanes per vector
AW, 20, DFRAM address width (core addr)
PW, 24, pixel counter width
TIMEOUT, 64, max cycles from core_start to core_done before error

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_num_groups  in  AW  channel groups per pixel (entries per pixel); must be ≥1
cfg_num_pix  in  PW  pixels in layer; must be ≥1
cfg_out_zp  in  8  signed output zero-point
layer_start  in  1  pulse: latch cfg_*, begin layer
busy  out  1  high from layer_start accept until DONE/ERR exit
layer_done  out  1  1-cycle pulse after last OFM handshake
err_timeout  out  1  sticky; cleared only by rst or next accepted layer_start
acc_valid  in  1  accumulator vector valid
acc_ready  out  1  accumulator vector accepted this cycle
acc_vec  in  LANES*32  accumulator vector
core_start  out  1  single-cycle start to core
core_addr  out  AW  DFRAM entry = current group index
core_acc_vec  out  LANES*32  registered acc vector held to core
core_out_zp  out  8  latched zero-point
core_ready  in  1  core idle
core_done  in  1  core result valid (ofm_vec valid this cycle)
core_ofm_vec  in  LANES*8  core result
ofm_valid  out  1  output vector valid
ofm_ready  in  1  downstream accept
ofm_data  out  LANES*8  registered output vector
ofm_last  out  1  qualifies final vector of layer

Behaviour:
- Reset: all outputs 0; state IDLE; grp_cnt = 0; pix_cnt = 0; wdog = 0; latched cfg = 0.
- Mid-operation reset: return to IDLE immediately; an in-flight core result is discarded.
- States and transitions:
  - IDLE: acc_ready = 0. On layer_start, latch cfg, clear counters and err_timeout, then go to FETCH. layer_start is ignored in any state other than IDLE.
  - FETCH: acc_ready = core_ready. On acc_valid & acc_ready, register acc_vec into core_acc_vec and go to ISSUE. acc_ready is combinational on core_ready and state only, never on acc_valid.
  - ISSUE: core_start = 1 for exactly one cycle, core_addr = grp_cnt, wdog cleared, then go to WAIT.
  - WAIT: wdog increments each cycle.
    - On core_done: capture core_ofm_vec into ofm_data, set ofm_valid, set ofm_last = (grp_cnt == num_groups-1 && pix_cnt == num_pix-1), go to HOLD.
    - Else if wdog reaches TIMEOUT-1: set err_timeout, go to ERR.
  - HOLD: ofm_valid and ofm_data are held stable until ofm_ready. On handshake:
    - clear ofm_valid.
    - If grp_cnt == num_groups-1, wrap grp_cnt to 0 and increment pix_cnt; else increment grp_cnt.
    - If this was the last vector, go to DONE; else go to FETCH.
  - DONE: pulse layer_done for one cycle, clear busy, go to IDLE.
  - ERR: busy = 0, acc_ready = 0, ofm_valid = 0; stay until rst or layer_start (re-arm as in IDLE).
- core_addr and core_acc_vec are held constant from ISSUE through the WAIT exit.
- core_out_zp is driven from latched cfg and is constant for the whole layer.
- Nominal per-vector latency with the core done 2 clk after start and ofm_ready held high: acc handshake at cycle T, core_start at T+1, core_done at T+3, ofm_valid at T+4, next acc_ready at T+5. One vector is completed every 5 cycles.
- A core_done arriving outside WAIT is ignored.
- Counter widths: grp_cnt is AW bits, pix_cnt is PW bits.
- Wrap occurs only on equality with the latched cfg minus 1, with no overflow paths. cfg values of 0 are illegal; behaviour for them is treated as num = 1.
- ofm_last is held while ofm_valid is high and is 0 otherwise.

Test Plan:
- num_groups = 3, num_pix = 2, acc_valid always high, ofm_ready always high:
  - core_addr sequence is 0,1,2,0,1,2.
  - There are 6 core_start pulses spaced 5 cycles apart.
  - ofm_last is high only on the 6th vector.
  - layer_done pulses 1 cycle after the 6th handshake.
- ofm_ready low for 7 cycles on vector 2: ofm_data/ofm_valid stay stable, acc_ready stays 0, and no second core_start is issued until the handshake.
- Core stub that never asserts done, TIMEOUT = 64:
  - err_timeout rises exactly 64 cycles after core_start and busy drops.
  - A following layer_start clears err_timeout and the run completes normally.
- rst asserted during WAIT of vector 4:
  - All outputs are 0 asynchronously.
  - A late core_done is ignored.
  - A fresh layer_start restarts at core_addr 0.
- cfg_out_zp = 37 and acc_valid toggling randomly:
  - core_out_zp = 37 throughout the layer.
  - Every acc vector appears unchanged on core_acc_vec.
  - OFM matches the golden file for layer 3 with zero mismatches.
- layer_start pulsed while busy: ignored, and the counters and cfg are unchanged.
